// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - arbitrates two dcache and two icache requesters onto one RAM port
// Dcache grants hold the port for a whole block; data and instruction classes alternate.
module memory_arbiter #(
    parameter int CPUS  = 2,
    parameter int BURST = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CPUS-1:0]           iREN,
    input  logic [CPUS-1:0][31:0]     iaddr,
    output logic [CPUS-1:0]           iwait,
    output logic [CPUS-1:0][31:0]     iload,
    input  logic [CPUS-1:0]           dREN,
    input  logic [CPUS-1:0]           dWEN,
    input  logic [CPUS-1:0][31:0]     daddr,
    input  logic [CPUS-1:0][31:0]     dstore,
    output logic [CPUS-1:0]           dwait,
    output logic [CPUS-1:0][31:0]     dload,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  logic [31:0]               ramload,
    input  logic                      ramwait
);

    localparam int WCW = $clog2(BURST) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_owner;
    logic             r_rr_d;
    logic             r_rr_i;
    logic             r_last_d;
    logic [WCW-1:0]   r_wcnt;

    logic [CPUS-1:0]  w_dreq;
    logic             w_any_d;
    logic             w_any_i;
    logic             w_d_pick;
    logic             w_i_pick;
    logic             w_own_dreq;
    logic             w_own_ireq;
    logic [WCW-1:0]   w_wcnt_inc;
    logic             w_exit_d;
    logic             w_exit_i;

    assign w_dreq     = dREN | dWEN;
    assign w_any_d    = |w_dreq;
    assign w_any_i    = |iREN;
    // A lone requester wins outright; a tie goes to the class pointer.
    assign w_d_pick   = (w_dreq[0] && w_dreq[1]) ? r_rr_d : w_dreq[1];
    assign w_i_pick   = (iREN[0] && iREN[1]) ? r_rr_i : iREN[1];
    assign w_own_dreq = w_dreq[r_owner];
    assign w_own_ireq = iREN[r_owner];
    assign w_wcnt_inc = r_wcnt + WCW'(1);

    assign dload = {CPUS{ramload}};
    assign iload = {CPUS{ramload}};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_rr_d   <= 1'b0;
            r_rr_i   <= 1'b0;
            r_last_d <= 1'b0;
            r_wcnt   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_state_next == IGRANT) begin
                        r_owner <= w_i_pick;
                        r_wcnt  <= '0;
                    end else if (w_state_next == DGRANT) begin
                        r_owner <= w_d_pick;
                        r_wcnt  <= '0;
                    end
                end
                DGRANT: begin
                    if (w_own_dreq && !ramwait) begin
                        r_wcnt <= w_wcnt_inc;
                    end
                    if (w_exit_d) begin
                        r_rr_d   <= ~r_owner;
                        r_last_d <= 1'b1;
                    end
                end
                IGRANT: begin
                    if (w_exit_i) begin
                        r_rr_i   <= ~r_owner;
                        r_last_d <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_exit_d     = 1'b0;
        w_exit_i     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_i && (!w_any_d || r_last_d)) begin
                    w_state_next = IGRANT;
                end else if (w_any_d) begin
                    w_state_next = DGRANT;
                end
            end
            DGRANT: begin
                if (!w_own_dreq || (!ramwait && (w_wcnt_inc == WCW'(BURST)))) begin
                    w_state_next = IDLE;
                    w_exit_d     = 1'b1;
                end
            end
            IGRANT: begin
                if (!w_own_ireq || !ramwait) begin
                    w_state_next = IDLE;
                    w_exit_i     = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (r_state)
            DGRANT: begin
                if (w_own_dreq) begin
                    // A simultaneous read and write is served as a write.
                    ramWEN         = dWEN[r_owner];
                    ramREN         = dREN[r_owner] & ~dWEN[r_owner];
                    ramaddr        = daddr[r_owner];
                    ramstore       = dstore[r_owner];
                    dwait[r_owner] = ramwait;
                end
            end
            IGRANT: begin
                if (w_own_ireq) begin
                    ramREN         = 1'b1;
                    ramaddr        = iaddr[r_owner];
                    iwait[r_owner] = ramwait;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;

    logic             CLK;
    logic             RST;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       dwait;
    logic [1:0][31:0] dload;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic             ramwait;

    int total;
    int passed;

    memory_arbiter #(.CPUS(2), .BURST(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramwait(ramwait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN    = 2'b00;
        dREN    = 2'b00;
        dWEN    = 2'b00;
        iaddr   = '0;
        daddr   = '0;
        dstore  = '0;
        ramwait = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        int pat [10];
        logic [31:0] exp_addr;
        logic [1:0]  exp_dw;
        logic [1:0]  exp_iw;
        total   = 0;
        passed  = 0;
        pat     = '{0, 0, 4, 2, 4, 1, 1, 4, 3, 4};
        ramload = 32'hA5A5_0001;
        clear_inputs();
        RST = 1'b1;
        tick();

        // Reset state
        #1;
        chk("rst_state", 32'(dut.r_state), 32'd0);
        chk("rst_iwait", 32'(iwait), 32'd3);
        chk("rst_dwait", 32'(dwait), 32'd3);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_dload1", dload[1], 32'hA5A5_0001);
        chk("rst_iload0", iload[0], 32'hA5A5_0001);
        RST = 1'b0;
        tick();

        // Single read, requester drops after its word
        dREN[0]  = 1'b1;
        daddr[0] = 32'h100;
        ramload  = 32'hDEAD_BEEF;
        #1;
        chk("rd_c0_ramREN", 32'(ramREN), 32'd0);
        chk("rd_c0_dwait", 32'(dwait), 32'd3);
        tick();
        #1;
        chk("rd_c1_ramREN", 32'(ramREN), 32'd1);
        chk("rd_c1_ramWEN", 32'(ramWEN), 32'd0);
        chk("rd_c1_ramaddr", ramaddr, 32'h100);
        chk("rd_c1_dwait", 32'(dwait), 32'd2);
        chk("rd_c1_dload0", dload[0], 32'hDEAD_BEEF);
        tick();
        dREN[0] = 1'b0;
        #1;
        chk("rd_c2_ramREN", 32'(ramREN), 32'd0);
        chk("rd_c2_dwait", 32'(dwait), 32'd3);
        tick();
        #1;
        chk("rd_c3_state", 32'(dut.r_state), 32'd0);
        chk("rd_c3_wcnt", 32'(dut.r_wcnt), 32'd1);

        // Atomic burst with competing dcache1
        do_reset();
        dREN     = 2'b11;
        daddr[0] = 32'h200;
        daddr[1] = 32'h300;
        tick();
        #1;
        chk("bu_c1_ramaddr", ramaddr, 32'h200);
        chk("bu_c1_dwait", 32'(dwait), 32'd2);
        tick();
        daddr[0] = 32'h204;
        #1;
        chk("bu_c2_ramaddr", ramaddr, 32'h204);
        chk("bu_c2_dwait", 32'(dwait), 32'd2);
        tick();
        dREN[0] = 1'b0;
        #1;
        chk("bu_c3_ramREN", 32'(ramREN), 32'd0);
        chk("bu_c3_dwait", 32'(dwait), 32'd3);
        chk("bu_c3_rr_d", 32'(dut.r_rr_d), 32'd1);
        tick();
        #1;
        chk("bu_c4_ramaddr", ramaddr, 32'h300);
        chk("bu_c4_dwait", 32'(dwait), 32'd1);
        tick();
        daddr[1] = 32'h304;
        #1;
        chk("bu_c5_ramaddr", ramaddr, 32'h304);
        tick();
        dREN[1] = 1'b0;
        #1;
        chk("bu_c6_state", 32'(dut.r_state), 32'd0);
        chk("bu_c6_rr_d", 32'(dut.r_rr_d), 32'd0);

        // Class fairness: all four requesters held
        do_reset();
        dREN     = 2'b11;
        iREN     = 2'b11;
        daddr[0] = 32'h1000;
        daddr[1] = 32'h2000;
        iaddr[0] = 32'h3000;
        iaddr[1] = 32'h4000;
        #1;
        chk("fa_c0_ramaddr", ramaddr, 32'd0);
        tick();
        for (int c = 1; c <= 20; c++) begin
            #1;
            exp_addr = 32'd0;
            exp_dw   = 2'b11;
            exp_iw   = 2'b11;
            case (pat[(c - 1) % 10])
                0: begin exp_addr = 32'h1000; exp_dw = 2'b10; end
                1: begin exp_addr = 32'h2000; exp_dw = 2'b01; end
                2: begin exp_addr = 32'h3000; exp_iw = 2'b10; end
                3: begin exp_addr = 32'h4000; exp_iw = 2'b01; end
                default: ;
            endcase
            chk($sformatf("fa_c%0d_ramaddr", c), ramaddr, exp_addr);
            chk($sformatf("fa_c%0d_dwait", c), 32'(dwait), 32'(exp_dw));
            chk($sformatf("fa_c%0d_iwait", c), 32'(iwait), 32'(exp_iw));
            tick();
        end

        // RAM stalls on a dcache write
        do_reset();
        dWEN[0]   = 1'b1;
        daddr[0]  = 32'h40;
        dstore[0] = 32'h1234_5678;
        ramwait   = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("st_c%0d_ramWEN", c), 32'(ramWEN), 32'd1);
            chk($sformatf("st_c%0d_ramstore", c), ramstore, 32'h1234_5678);
            chk($sformatf("st_c%0d_dwait", c), 32'(dwait), 32'd3);
            chk($sformatf("st_c%0d_wcnt", c), 32'(dut.r_wcnt), 32'd0);
            tick();
        end
        ramwait = 1'b0;
        #1;
        chk("st_c4_ramWEN", 32'(ramWEN), 32'd1);
        chk("st_c4_ramaddr", ramaddr, 32'h40);
        chk("st_c4_dwait", 32'(dwait), 32'd2);
        tick();
        dWEN[0] = 1'b0;
        #1;
        chk("st_c5_wcnt", 32'(dut.r_wcnt), 32'd1);
        chk("st_c5_ramWEN", 32'(ramWEN), 32'd0);
        tick();
        #1;
        chk("st_c6_state", 32'(dut.r_state), 32'd0);

        // Reset during a dcache grant clears pointers
        do_reset();
        dREN[0]  = 1'b1;
        iREN[0]  = 1'b1;
        daddr[0] = 32'h500;
        iaddr[0] = 32'h600;
        for (int c = 0; c < 8; c++) tick();
        iREN[0] = 1'b0;
        #1;
        chk("rs_c8_rr_d", 32'(dut.r_rr_d), 32'd1);
        chk("rs_c8_rr_i", 32'(dut.r_rr_i), 32'd1);
        chk("rs_c8_last_d", 32'(dut.r_last_d), 32'd1);
        tick();
        #1;
        chk("rs_c9_ramREN", 32'(ramREN), 32'd1);
        chk("rs_c9_ramaddr", ramaddr, 32'h500);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("rs_c10_state", 32'(dut.r_state), 32'd0);
        chk("rs_c10_ramREN", 32'(ramREN), 32'd0);
        chk("rs_c10_dwait", 32'(dwait), 32'd3);
        chk("rs_c10_rr_d", 32'(dut.r_rr_d), 32'd0);
        chk("rs_c10_rr_i", 32'(dut.r_rr_i), 32'd0);
        chk("rs_c10_last_d", 32'(dut.r_last_d), 32'd0);

        // Read/write conflict is served as a write
        do_reset();
        dREN[1]   = 1'b1;
        dWEN[1]   = 1'b1;
        daddr[1]  = 32'h80;
        dstore[1] = 32'hCAFE_F00D;
        tick();
        #1;
        chk("cf_ramWEN", 32'(ramWEN), 32'd1);
        chk("cf_ramREN", 32'(ramREN), 32'd0);
        chk("cf_ramstore", ramstore, 32'hCAFE_F00D);
        chk("cf_ramaddr", ramaddr, 32'h80);
        chk("cf_dwait", 32'(dwait), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
